ram_bus_arbiter: RTL and testbench

- Shares the single-port RAM between two masters: the CPU controller's memory path (CPU) and the program loader/debug DMA (DMA).
- Grants one owner at a time and issues pipelined single-beat accesses, one per cycle.
- Inserts one dead turnaround cycle on every ownership change so bus drivers never overlap.
- Bounds bus tenure so neither master starves the other.

---
 rtl/ram_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one single-port RAM between the CPU memory path and the
// loader/debug DMA. It grants one owner at a time and issues one pipelined single-beat
// access per cycle. Every ownership change passes through a one-cycle TURN state, and
// bus tenure is bounded while the other master is waiting.
//
// Optional build macro: ARB_LOCK_EN. When defined, it adds CPU_LOCK and DMA_LOCK inputs.
// While the owner holds its LOCK high, forced release is suppressed.
//
// Ports:
//   CLK, RST                 clock; asynchronous active-high reset
//   CPU_LOCK, DMA_LOCK       (ARB_LOCK_EN only) owner lock against forced release
//   CPU_REQ/WE/ADDR/WDATA    CPU request; held stable until ACK
//   CPU_GNT/ACK/RDATA        CPU grant, one-cycle completion pulse, read data
//   DMA_*                    same as CPU_* for the DMA master
//   RAM_EN/RW/ADDR/WDATA     RAM strobe, 1=read/0=write, address, write data
//   RAM_RDATA                RAM read data
module ram_bus_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef ARB_LOCK_EN
  input  logic              CPU_LOCK,
  input  logic              DMA_LOCK,
`endif
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic [ADDR_W-1:0] DMA_ADDR,
  input  logic [DATA_W-1:0] DMA_WDATA,
  output logic              DMA_GNT,
  output logic              DMA_ACK,
  output logic [DATA_W-1:0] DMA_RDATA,
  output logic              RAM_EN,
  output logic              RAM_RW,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA
);

  typedef enum logic [1:0] {StIdle, StOwnCpu, StOwnDma, StTurn} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_dma_q, last_dma_d;  // last owner: 0 = CPU, 1 = DMA
  logic              issue_cpu, issue_dma;
  logic              cpu_lock, dma_lock;

  logic              cpu_gnt_q, dma_gnt_q;
  logic              ram_en_q, ram_rw_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              tag_dma_q;               // owner of the access currently on the RAM
  logic              cpu_ack_q, dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

`ifdef ARB_LOCK_EN
  assign cpu_lock = CPU_LOCK;
  assign dma_lock = DMA_LOCK;
`else
  assign cpu_lock = 1'b0;
  assign dma_lock = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dma_d = last_dma_q;
    issue_cpu  = 1'b0;
    issue_dma  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // DMA wins a simultaneous request.
        if (DMA_REQ) begin
          state_d = StOwnDma;
          cnt_d   = '0;
        end else if (CPU_REQ) begin
          state_d = StOwnCpu;
          cnt_d   = '0;
        end
      end
      StOwnCpu: begin
        if (!CPU_REQ || (cnt_q >= MaxBurst && DMA_REQ && !cpu_lock)) begin
          state_d    = StTurn;
          last_dma_d = 1'b0;
        end else begin
          issue_cpu = 1'b1;
          cnt_d     = (cnt_q >= MaxBurst) ? cnt_q : cnt_q + 4'd1;
        end
      end
      StOwnDma: begin
        if (!DMA_REQ || (cnt_q >= MaxBurst && CPU_REQ && !dma_lock)) begin
          state_d    = StTurn;
          last_dma_d = 1'b1;
        end else begin
          issue_dma = 1'b1;
          cnt_d     = (cnt_q >= MaxBurst) ? cnt_q : cnt_q + 4'd1;
        end
      end
      StTurn: begin
        // Prefer the master that did not own the bus last.
        if (last_dma_q ? CPU_REQ : DMA_REQ) begin
          state_d = last_dma_q ? StOwnCpu : StOwnDma;
          cnt_d   = '0;
        end else if (last_dma_q ? DMA_REQ : CPU_REQ) begin
          state_d = last_dma_q ? StOwnDma : StOwnCpu;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_dma_q  <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag_dma_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dma_q <= last_dma_d;
      cpu_gnt_q  <= (state_d == StOwnCpu);
      dma_gnt_q  <= (state_d == StOwnDma);

      // Stage 1: drive the RAM and remember who issued.
      ram_en_q  <= issue_cpu | issue_dma;
      tag_dma_q <= issue_dma;
      if (issue_dma) begin
        ram_rw_q    <= ~DMA_WE;
        ram_addr_q  <= DMA_ADDR;
        ram_wdata_q <= DMA_WDATA;
      end else if (issue_cpu) begin
        ram_rw_q    <= ~CPU_WE;
        ram_addr_q  <= CPU_ADDR;
        ram_wdata_q <= CPU_WDATA;
      end

      // Stage 2: route completion by tag, independent of the current state.
      cpu_ack_q <= ram_en_q & ~tag_dma_q;
      dma_ack_q <= ram_en_q & tag_dma_q;
      if (ram_en_q && ram_rw_q && !tag_dma_q) cpu_rdata_q <= RAM_RDATA;
      if (ram_en_q && ram_rw_q && tag_dma_q)  dma_rdata_q <= RAM_RDATA;
    end
  end

  assign CPU_GNT   = cpu_gnt_q;
  assign DMA_GNT   = dma_gnt_q;
  assign CPU_ACK   = cpu_ack_q;
  assign DMA_ACK   = dma_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign DMA_RDATA = dma_rdata_q;
  assign RAM_EN    = ram_en_q;
  assign RAM_RW    = ram_rw_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter (ADDR_W = DATA_W = 8, MAX_BURST = 4).
// The lock scenario is built only when ARB_LOCK_EN is defined.
module tb_ram_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_lock, dma_lock;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_gnt, cpu_ack;
  logic       dma_req, dma_we;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       dma_gnt, dma_ack;
  logic       ram_en, ram_rw;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  // Reactive master models: advance to the next write once it is seen on the RAM bus.
  bit         dma_drv = 1'b0;
  bit         cpu_drv = 1'b0;
  int         dma_n, dma_len, cpu_n, cpu_len;
  logic [7:0] dma_base;

  ram_bus_arbiter #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .MAX_BURST(4)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
`ifdef ARB_LOCK_EN
    .CPU_LOCK (cpu_lock),
    .DMA_LOCK (dma_lock),
`endif
    .CPU_REQ  (cpu_req),
    .CPU_WE   (cpu_we),
    .CPU_ADDR (cpu_addr),
    .CPU_WDATA(cpu_wdata),
    .CPU_GNT  (cpu_gnt),
    .CPU_ACK  (cpu_ack),
    .CPU_RDATA(cpu_rdata),
    .DMA_REQ  (dma_req),
    .DMA_WE   (dma_we),
    .DMA_ADDR (dma_addr),
    .DMA_WDATA(dma_wdata),
    .DMA_GNT  (dma_gnt),
    .DMA_ACK  (dma_ack),
    .DMA_RDATA(dma_rdata),
    .RAM_EN   (ram_en),
    .RAM_RW   (ram_rw),
    .RAM_ADDR (ram_addr),
    .RAM_WDATA(ram_wdata),
    .RAM_RDATA(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (dma_drv && dma_req && ram_en && !ram_rw && ram_wdata == dma_wdata) begin
      dma_n++;
      dma_addr  = dma_base + 8'(dma_n);
      dma_wdata = 8'hA0 + 8'(dma_n);
      if (dma_n == dma_len) dma_req = 1'b0;
    end
    if (cpu_drv && cpu_req && ram_en && !ram_rw && ram_wdata == cpu_wdata) begin
      cpu_n++;
      cpu_addr  = 8'h20 + 8'(cpu_n);
      cpu_wdata = 8'h30 + 8'(cpu_n);
      if (cpu_n == cpu_len) cpu_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_lock = 1'b0; dma_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
    ram_rdata = 8'h5A;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_cpu_gnt", 8'(cpu_gnt), 8'h0);
    chk("rst_dma_gnt", 8'(dma_gnt), 8'h0);
    chk("rst_ram_en", 8'(ram_en), 8'h0);
    chk("rst_ram_rw", 8'(ram_rw), 8'h1);
    chk("rst_ram_addr", ram_addr, 8'h00);
    chk("rst_cpu_ack", 8'(cpu_ack), 8'h0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);

    // Single CPU read from IDLE
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step();  // cycle 1
    chk("rd_c1_cpu_gnt", 8'(cpu_gnt), 8'h1);
    chk("rd_c1_ram_en", 8'(ram_en), 8'h0);
    step();  // cycle 2
    chk("rd_c2_ram_en", 8'(ram_en), 8'h1);
    chk("rd_c2_ram_rw", 8'(ram_rw), 8'h1);
    chk("rd_c2_ram_addr", ram_addr, 8'h10);
    chk("rd_c2_cpu_ack", 8'(cpu_ack), 8'h0);
    cpu_req = 1'b0;
    step();  // cycle 3: TURN, ACK of the read
    chk("rd_c3_cpu_ack", 8'(cpu_ack), 8'h1);
    chk("rd_c3_cpu_rdata", cpu_rdata, 8'h5A);
    chk("rd_c3_cpu_gnt", 8'(cpu_gnt), 8'h0);
    chk("rd_c3_ram_en", 8'(ram_en), 8'h0);
    step();  // cycle 4: IDLE
    chk("rd_c4_cpu_ack", 8'(cpu_ack), 8'h0);

    // Simultaneous request, then DMA stream of 10 writes against a waiting CPU
    dma_base = 8'h00; dma_n = 0; dma_len = 10; dma_drv = 1'b1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h00; dma_wdata = 8'hA0;
    cpu_n = 0; cpu_len = 2; cpu_drv = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h30;
    step();  // t1
    chk("arb_t1_dma_gnt", 8'(dma_gnt), 8'h1);
    chk("arb_t1_cpu_gnt", 8'(cpu_gnt), 8'h0);
    step();  // t2
    chk("str_t2_ram_en", 8'(ram_en), 8'h1);
    chk("str_t2_ram_rw", 8'(ram_rw), 8'h0);
    chk("str_t2_ram_addr", ram_addr, 8'h00);
    chk("str_t2_ram_wdata", ram_wdata, 8'hA0);
    step();  // t3
    chk("str_t3_dma_ack", 8'(dma_ack), 8'h1);
    step();  // t4
    step();  // t5
    chk("str_t5_ram_addr", ram_addr, 8'h03);
    chk("str_t5_dma_gnt", 8'(dma_gnt), 8'h1);
    step();  // t6: TURN after forced release
    chk("str_t6_ram_en", 8'(ram_en), 8'h0);
    chk("str_t6_dma_gnt", 8'(dma_gnt), 8'h0);
    chk("str_t6_cpu_gnt", 8'(cpu_gnt), 8'h0);
    chk("str_t6_dma_ack", 8'(dma_ack), 8'h1);
    chk("str_t6_dma_pulses", 8'(dma_n), 8'd4);
    step();  // t7
    chk("str_t7_cpu_gnt", 8'(cpu_gnt), 8'h1);
    chk("str_t7_ram_en", 8'(ram_en), 8'h0);
    step();  // t8
    chk("str_t8_ram_addr", ram_addr, 8'h20);
    chk("str_t8_ram_wdata", ram_wdata, 8'h30);
    step();  // t9
    chk("str_t9_ram_addr", ram_addr, 8'h21);
    step();  // t10: TURN, ACK of the CPU's second write
    chk("str_t10_cpu_ack", 8'(cpu_ack), 8'h1);
    chk("str_t10_cpu_gnt", 8'(cpu_gnt), 8'h0);
    chk("str_t10_ram_en", 8'(ram_en), 8'h0);
    step();  // t11
    chk("str_t11_dma_gnt", 8'(dma_gnt), 8'h1);
    repeat (5) step();  // t16: counter saturated, no forced release
    chk("str_t16_ram_addr", ram_addr, 8'h08);
    step();  // t17
    chk("str_t17_ram_en", 8'(ram_en), 8'h1);
    chk("str_t17_ram_addr", ram_addr, 8'h09);
    step();  // t18
    chk("str_t18_ram_en", 8'(ram_en), 8'h0);
    chk("str_t18_dma_ack", 8'(dma_ack), 8'h1);
    step();  // t19: IDLE
    chk("str_t19_dma_gnt", 8'(dma_gnt), 8'h0);
    chk("str_t19_dma_ack", 8'(dma_ack), 8'h0);
    chk("str_t19_dma_total", 8'(dma_n), 8'd10);
    chk("str_t19_cpu_rdata_held", cpu_rdata, 8'h5A);
    dma_drv = 1'b0; cpu_drv = 1'b0;

    // CPU single write then release with DMA idle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
    step();  // s1
    chk("wr_s1_cpu_gnt", 8'(cpu_gnt), 8'h1);
    step();  // s2
    chk("wr_s2_ram_en", 8'(ram_en), 8'h1);
    chk("wr_s2_ram_rw", 8'(ram_rw), 8'h0);
    chk("wr_s2_ram_wdata", ram_wdata, 8'h77);
    cpu_req = 1'b0;
    step();  // s3: TURN
    chk("wr_s3_cpu_gnt", 8'(cpu_gnt), 8'h0);
    chk("wr_s3_ram_en", 8'(ram_en), 8'h0);
    chk("wr_s3_cpu_ack", 8'(cpu_ack), 8'h1);
    step();  // s4: IDLE
    chk("wr_s4_cpu_ack", 8'(cpu_ack), 8'h0);
    chk("wr_s4_cpu_gnt", 8'(cpu_gnt), 8'h0);
    chk("wr_s4_cpu_rdata", cpu_rdata, 8'h5A);

    // Reset while a DMA read is in flight
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h55; ram_rdata = 8'hC3;
    step();  // r1
    chk("rr_r1_dma_gnt", 8'(dma_gnt), 8'h1);
    step();  // r2
    chk("rr_r2_ram_en", 8'(ram_en), 8'h1);
    dma_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rr_async_ram_en", 8'(ram_en), 8'h0);
    chk("rr_async_dma_gnt", 8'(dma_gnt), 8'h0);
    chk("rr_async_ram_addr", ram_addr, 8'h00);
    chk("rr_async_cpu_rdata", cpu_rdata, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rr_post1_dma_ack", 8'(dma_ack), 8'h0);
    step();
    chk("rr_post2_dma_ack", 8'(dma_ack), 8'h0);
    chk("rr_post2_dma_rdata", dma_rdata, 8'h00);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h66; ram_rdata = 8'h99;
    step();
    chk("rr_q1_cpu_gnt", 8'(cpu_gnt), 8'h1);
    step();
    chk("rr_q2_ram_addr", ram_addr, 8'h66);
    cpu_req = 1'b0;
    step();
    chk("rr_q3_cpu_ack", 8'(cpu_ack), 8'h1);
    chk("rr_q3_cpu_rdata", cpu_rdata, 8'h99);
    step();

`ifdef ARB_LOCK_EN
    // DMA holds LOCK for 6 accesses while the CPU waits
    dma_base = 8'h80; dma_n = 0; dma_len = 15; dma_drv = 1'b1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h80; dma_wdata = 8'hA0; dma_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h70;
    step();  // u1
    chk("lk_u1_dma_gnt", 8'(dma_gnt), 8'h1);
    repeat (5) step();  // u6
    chk("lk_u6_ram_addr", ram_addr, 8'h84);
    step();  // u7: sixth access on the RAM
    chk("lk_u7_ram_en", 8'(ram_en), 8'h1);
    chk("lk_u7_ram_addr", ram_addr, 8'h85);
    chk("lk_u7_dma_gnt", 8'(dma_gnt), 8'h1);
    dma_lock = 1'b0;
    step();  // u8: TURN
    chk("lk_u8_ram_en", 8'(ram_en), 8'h0);
    chk("lk_u8_dma_gnt", 8'(dma_gnt), 8'h0);
    chk("lk_u8_cpu_gnt", 8'(cpu_gnt), 8'h0);
    chk("lk_u8_dma_count", 8'(dma_n), 8'd6);
    step();  // u9
    chk("lk_u9_cpu_gnt", 8'(cpu_gnt), 8'h1);
    dma_drv = 1'b0;
    dma_req = 1'b0; cpu_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
